mem_bus_arbiter: RTL and testbench

Arbiter and sequencer that shares one single-ported memory bus between instruction fetch (driven by the PC register's `pc`/`ce`) and the MEM-stage data access. It runs bus transactions, returns read data to IF or MEM, and generates the pipeline `stall[5:0]` vector consumed by the PC register and the stage registers. `stall[0]`=PC, `stall[1]`=IF, … `stall[5]`=WB; a bit of 1 means stop.

---
 rtl/mem_bus_arbiter.sv | 173 +++++++++++++++++
 tb/tb_mem_bus_arbiter.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_bus_arbiter.sv
// Shares one single-ported memory bus between instruction fetch and MEM-stage data access.
// Optional feature: define BUS_TIMEOUT_EN for a 255-cycle bus timeout with a bus_err_o pulse.
module mem_bus_arbiter (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_ce_i,
  input  logic [31:0] if_addr_i,
  output logic [31:0] if_data_o,
  input  logic        mem_req_i,
  input  logic        mem_we_i,
  input  logic [31:0] mem_addr_i,
  input  logic [31:0] mem_wdata_i,
  input  logic [3:0]  mem_sel_i,
  output logic [31:0] mem_rdata_o,
  input  logic        flush_i,
  output logic        bus_req_o,
  output logic        bus_we_o,
  output logic [31:0] bus_addr_o,
  output logic [31:0] bus_wdata_o,
  output logic [3:0]  bus_sel_o,
  input  logic [31:0] bus_rdata_i,
  input  logic        bus_ack_i,
  output logic        bus_err_o,
  output logic [5:0]  stall_o
);

  typedef enum logic [1:0] {StIdle, StFetch, StData} state_e;

  localparam logic [5:0] StallNone  = 6'b000000;
  localparam logic [5:0] StallFetch = 6'b000011;
  localparam logic [5:0] StallAll   = 6'b011111;

  state_e      r_state;
  logic        r_ibuf_valid;
  logic [31:0] r_ibuf;
  logic        r_stale;

  logic        w_done;
  logic        w_stale;
  logic        w_ibuf_ok;
  logic [31:0] w_rdata;
  logic [31:0] w_if_data;
  logic [31:0] w_mem_rdata;
  logic [5:0]  w_stall;

`ifdef BUS_TIMEOUT_EN
  logic [7:0] r_cnt;
  logic       w_timeout;

  assign w_timeout = (r_state != StIdle) && (r_cnt == 8'hFF);
  assign w_done    = bus_req_o & (bus_ack_i | w_timeout);
  assign w_rdata   = bus_ack_i ? bus_rdata_i : 32'h0;
  assign bus_err_o = w_timeout & ~bus_ack_i;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= 8'h00;
    end else if (r_state == StIdle) begin
      r_cnt <= 8'h00;
    end else if (!bus_ack_i) begin
      r_cnt <= r_cnt + 8'h01;
    end
  end
`else
  assign w_done    = bus_req_o & bus_ack_i;
  assign w_rdata   = bus_rdata_i;
  assign bus_err_o = 1'b0;
`endif

  // A flush coinciding with an ack takes effect immediately.
  assign w_stale   = r_stale | flush_i;
  assign w_ibuf_ok = r_ibuf_valid & ~flush_i;

  always_comb begin
    w_stall     = StallNone;
    w_if_data   = 32'h0;
    w_mem_rdata = 32'h0;
    case (r_state)
      StIdle: begin
        if (mem_req_i) begin
          w_stall = StallAll;
        end else if (if_ce_i && !r_ibuf_valid) begin
          w_stall = StallFetch;
        end
      end
      StFetch: begin
        if (w_done && !w_stale && !mem_req_i) begin
          w_if_data = w_rdata;
        end else begin
          w_stall = mem_req_i ? StallAll : StallFetch;
        end
      end
      StData: begin
        if (!w_done) begin
          w_stall = StallAll;
        end else begin
          w_mem_rdata = bus_we_o ? 32'h0 : w_rdata;
          if (w_ibuf_ok) begin
            w_if_data = r_ibuf;
          end else begin
            w_stall = StallFetch;
          end
        end
      end
      default: ;
    endcase
  end

  assign stall_o     = rst ? StallNone : w_stall;
  assign if_data_o   = if_ce_i ? w_if_data : 32'h0;
  assign mem_rdata_o = w_mem_rdata;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= StIdle;
      r_ibuf_valid <= 1'b0;
      r_ibuf       <= 32'h0;
      r_stale      <= 1'b0;
      bus_req_o    <= 1'b0;
      bus_we_o     <= 1'b0;
      bus_addr_o   <= 32'h0;
      bus_wdata_o  <= 32'h0;
      bus_sel_o    <= 4'h0;
    end else begin
      if (flush_i) begin
        r_ibuf_valid <= 1'b0;
      end
      case (r_state)
        StIdle: begin
          if (mem_req_i) begin
            bus_req_o   <= 1'b1;
            bus_we_o    <= mem_we_i;
            bus_addr_o  <= mem_addr_i;
            bus_wdata_o <= mem_wdata_i;
            bus_sel_o   <= mem_sel_i;
            r_state     <= StData;
          end else if (if_ce_i && !r_ibuf_valid) begin
            bus_req_o   <= 1'b1;
            bus_we_o    <= 1'b0;
            bus_addr_o  <= if_addr_i;
            bus_wdata_o <= 32'h0;
            bus_sel_o   <= 4'hF;
            r_stale     <= 1'b0;
            r_state     <= StFetch;
          end
        end
        StFetch: begin
          if (w_done) begin
            bus_req_o <= 1'b0;
            r_stale   <= 1'b0;
            r_state   <= StIdle;
            // Park the instruction so the pending data access can run first.
            if (!w_stale && mem_req_i) begin
              r_ibuf       <= w_rdata;
              r_ibuf_valid <= 1'b1;
            end
          end else if (flush_i) begin
            r_stale <= 1'b1;
          end
        end
        StData: begin
          if (w_done) begin
            bus_req_o    <= 1'b0;
            r_ibuf_valid <= 1'b0;
            r_state      <= StIdle;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Randomized and directed bench for mem_bus_arbiter against a transaction-level model.
// Define BUS_TIMEOUT_EN to also exercise the bus timeout.
module tb_mem_bus_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        if_ce = 1'b0;
  logic [31:0] if_addr = 32'h0;
  logic        mem_req = 1'b0;
  logic        mem_we = 1'b0;
  logic [31:0] mem_addr = 32'h0;
  logic [31:0] mem_wdata = 32'h0;
  logic [3:0]  mem_sel = 4'h0;
  logic        flush = 1'b0;
  logic [31:0] bus_rdata = 32'h0;
  logic        bus_ack = 1'b0;

  logic [31:0] if_data_o;
  logic [31:0] mem_rdata_o;
  logic        bus_req_o;
  logic        bus_we_o;
  logic [31:0] bus_addr_o;
  logic [31:0] bus_wdata_o;
  logic [3:0]  bus_sel_o;
  logic        bus_err_o;
  logic [5:0]  stall_o;

  mem_bus_arbiter dut (
    .clk        (clk),
    .rst        (rst),
    .if_ce_i    (if_ce),
    .if_addr_i  (if_addr),
    .if_data_o  (if_data_o),
    .mem_req_i  (mem_req),
    .mem_we_i   (mem_we),
    .mem_addr_i (mem_addr),
    .mem_wdata_i(mem_wdata),
    .mem_sel_i  (mem_sel),
    .mem_rdata_o(mem_rdata_o),
    .flush_i    (flush),
    .bus_req_o  (bus_req_o),
    .bus_we_o   (bus_we_o),
    .bus_addr_o (bus_addr_o),
    .bus_wdata_o(bus_wdata_o),
    .bus_sel_o  (bus_sel_o),
    .bus_rdata_i(bus_rdata),
    .bus_ack_i  (bus_ack),
    .bus_err_o  (bus_err_o),
    .stall_o    (stall_o)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail = 0;

  // Transaction-level model: one outstanding bus transaction plus one held instruction.
  logic        m_busy = 1'b0;
  logic        m_data = 1'b0;
  logic [31:0] m_addr = 32'h0;
  logic        m_we = 1'b0;
  logic [31:0] m_wdata = 32'h0;
  logic [3:0]  m_sel = 4'h0;
  logic        m_stale = 1'b0;
  logic        m_hv = 1'b0;
  logic [31:0] m_held = 32'h0;
  int          m_age = 0;
  logic        last_dd = 1'b0;

  logic [31:0] o_stall, o_if, o_mr, o_req, o_addr, o_err;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_busy  = 1'b0;
    m_stale = 1'b0;
    m_hv    = 1'b0;
    m_age   = 0;
    last_dd = 1'b0;
  endtask

  // Sample at the falling edge, compare with the model, then advance model and clock.
  task automatic cycle();
    logic        done, to, old_hv;
    logic [31:0] rd, e_stall, e_if, e_mr;
    @(negedge clk);
    o_stall = 32'(stall_o);
    o_if    = if_data_o;
    o_mr    = mem_rdata_o;
    o_req   = 32'(bus_req_o);
    o_addr  = bus_addr_o;
    o_err   = 32'(bus_err_o);
    to = 1'b0;
`ifdef BUS_TIMEOUT_EN
    to = m_busy && (m_age == 255);
`endif
    done = m_busy && (bus_ack || to);
    rd = bus_ack ? bus_rdata : 32'h0;
    e_stall = 32'h00;
    e_if = 32'h0;
    e_mr = 32'h0;
    if (!m_busy) begin
      if (mem_req) e_stall = 32'h1F;
      else if (if_ce && !m_hv) e_stall = 32'h03;
    end else if (!m_data) begin
      if (done && !(m_stale || flush) && !mem_req) e_if = rd;
      else e_stall = mem_req ? 32'h1F : 32'h03;
    end else if (!done) begin
      e_stall = 32'h1F;
    end else begin
      e_mr = m_we ? 32'h0 : rd;
      if (m_hv && !flush) e_if = m_held;
      else e_stall = 32'h03;
    end
    if (!if_ce) e_if = 32'h0;
    check_eq("stall", o_stall, e_stall);
    check_eq("if_data", o_if, e_if);
    check_eq("mem_rdata", o_mr, e_mr);
    check_eq("bus_req", o_req, 32'(m_busy));
    check_eq("bus_err", o_err, 32'(to && !bus_ack));
    if (m_busy) begin
      check_eq("bus_addr", o_addr, m_addr);
      check_eq("bus_we", 32'(bus_we_o), 32'(m_we));
      check_eq("bus_wdata", bus_wdata_o, m_wdata);
      check_eq("bus_sel", 32'(bus_sel_o), 32'(m_sel));
    end
    last_dd = m_busy && m_data && done;
    old_hv = m_hv;
    if (flush) m_hv = 1'b0;
    if (!m_busy) begin
      if (mem_req) begin
        m_busy = 1'b1; m_data = 1'b1; m_addr = mem_addr; m_we = mem_we;
        m_wdata = mem_wdata; m_sel = mem_sel; m_age = 0;
      end else if (if_ce && !old_hv) begin
        m_busy = 1'b1; m_data = 1'b0; m_addr = if_addr; m_we = 1'b0;
        m_wdata = 32'h0; m_sel = 4'hF; m_stale = 1'b0; m_age = 0;
      end
    end else if (done) begin
      if (!m_data && !(m_stale || flush) && mem_req) begin
        m_held = rd;
        m_hv = 1'b1;
      end
      if (m_data) m_hv = 1'b0;
      m_busy = 1'b0;
      m_stale = 1'b0;
    end else begin
      if (!m_data && flush) m_stale = 1'b1;
      m_age++;
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    repeat (2) @(posedge clk);
    #1;
    if_ce = 1'b1;
    mem_req = 1'b1;
    #1;
    check_eq("rst_stall", 32'(stall_o), 32'h0);
    check_eq("rst_bus_req", 32'(bus_req_o), 32'h0);
    check_eq("rst_bus_addr", bus_addr_o, 32'h0);
    check_eq("rst_mem_rdata", mem_rdata_o, 32'h0);
    check_eq("rst_bus_err", 32'(bus_err_o), 32'h0);
    mem_req = 1'b0;
    if_ce = 1'b0;
    rst = 1'b0;
    model_reset();
    @(posedge clk);
    #1;

    // Fetch only
    if_ce = 1'b1; if_addr = 32'h100;
    cycle();
    check_eq("fo_idle_stall", o_stall, 32'h03);
    cycle();
    check_eq("fo_req_up", o_req, 32'h1);
    cycle();
    cycle();
    check_eq("fo_wait_stall", o_stall, 32'h03);
    bus_ack = 1'b1; bus_rdata = 32'hDEAD_0100;
    cycle();
    check_eq("fo_ack_stall", o_stall, 32'h00);
    check_eq("fo_ack_data", o_if, 32'hDEAD_0100);
    check_eq("fo_ack_addr", o_addr, 32'h100);
    bus_ack = 1'b0; if_ce = 1'b0;
    cycle();
    check_eq("fo_req_down", o_req, 32'h0);

    // Load priority over a pending fetch
    if_ce = 1'b1; if_addr = 32'h104;
    mem_req = 1'b1; mem_we = 1'b0; mem_addr = 32'h2000; mem_sel = 4'hF; mem_wdata = 32'h0;
    cycle();
    check_eq("lp_idle_stall", o_stall, 32'h1F);
    bus_ack = 1'b1; bus_rdata = 32'h1234_5678;
    cycle();
    check_eq("lp_addr", o_addr, 32'h2000);
    check_eq("lp_rdata", o_mr, 32'h1234_5678);
    check_eq("lp_ack_stall", o_stall, 32'h03);
    mem_req = 1'b0; bus_ack = 1'b0;
    cycle();
    check_eq("lp_fetch_stall", o_stall, 32'h03);
    bus_ack = 1'b1; bus_rdata = 32'hCAFE_0104;
    cycle();
    check_eq("lp_fetch_data", o_if, 32'hCAFE_0104);
    check_eq("lp_fetch_addr", o_addr, 32'h104);
    bus_ack = 1'b0;

    // Store arriving during the fetch ack: instruction is held
    if_addr = 32'h108;
    cycle();
    mem_req = 1'b1; mem_we = 1'b1; mem_addr = 32'h3000; mem_wdata = 32'h5555_AAAA;
    mem_sel = 4'h3; bus_ack = 1'b1; bus_rdata = 32'h0BAD_0108;
    cycle();
    check_eq("lf_fetch_stall", o_stall, 32'h1F);
    bus_rdata = 32'hFFFF_0000;
    cycle();
    check_eq("lf_idle_stall", o_stall, 32'h1F);
    bus_rdata = 32'h7777_7777;
    cycle();
    check_eq("lf_data_stall", o_stall, 32'h00);
    check_eq("lf_held_insn", o_if, 32'h0BAD_0108);
    check_eq("lf_store_rdata", o_mr, 32'h0);
    mem_req = 1'b0; bus_ack = 1'b0;

    // Flush during a fetch
    if_addr = 32'h200;
    cycle();
    flush = 1'b1; if_addr = 32'h300;
    cycle();
    flush = 1'b0; bus_ack = 1'b1; bus_rdata = 32'h1111_0200;
    cycle();
    check_eq("fl_ack_data", o_if, 32'h0);
    check_eq("fl_ack_stall", o_stall, 32'h03);
    bus_ack = 1'b0;
    cycle();
    cycle();
    check_eq("fl_new_pc", o_addr, 32'h300);
    check_eq("fl_new_req", o_req, 32'h1);

    // Reset while bus_req_o is high
    rst = 1'b1;
    #1;
    check_eq("rm_bus_req", 32'(bus_req_o), 32'h0);
    check_eq("rm_stall", 32'(stall_o), 32'h0);
    model_reset();
    #1;
    rst = 1'b0;
    cycle();
    check_eq("rm_idle_refetch", o_stall, 32'h03);

`ifdef BUS_TIMEOUT_EN
    // Unanswered transaction: bus_err_o pulses 255 cycles after bus_req_o rises
    while (m_busy) begin
      bus_ack = 1'b1;
      cycle();
    end
    bus_ack = 1'b0;
    cycle();
    k = 0;
    for (int i = 0; i < 300; i++) begin
      cycle();
      k++;
      if (o_err == 32'h1) break;
    end
    check_eq("to_latency", 32'(k), 32'd256);
    cycle();
    check_eq("to_err_once", o_err, 32'h0);
    check_eq("to_req_down", o_req, 32'h0);
`endif

    // Randomized traffic; a data request is held until its ack
    mem_req = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if (!(mem_req && !last_dd)) begin
        mem_req   = ($urandom % 4) == 0;
        mem_we    = 1'($urandom % 2);
        mem_addr  = $urandom & 32'hFFFF_FFFC;
        mem_wdata = $urandom;
        mem_sel   = 4'($urandom);
      end
      if_ce = ($urandom % 8) != 0;
      if (($urandom % 2) == 0) if_addr = $urandom & 32'hFFFF_FFFC;
      flush     = ($urandom % 16) == 0;
      bus_ack   = ($urandom % 2) == 0;
      bus_rdata = $urandom;
      cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
